// File: rtl/adder_share_arbiter_pkg.sv
// Shared datapath widths and response FSM states for the adder-sharing arbiter.
// Imported by the arbiter top and by the adder core.
package adder_share_arbiter_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned SUM_W  = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage : adder_share_arbiter_pkg

// File: rtl/adder_share_arbiter_four_bit_add.sv
// Shared 4-bit adder core: unsigned a + b with the carry returned in sum[4].
module four_bit_add
    import adder_share_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [SUM_W-1:0]  sum
);

    assign sum = {1'b0, a} + {1'b0, b};

endmodule : four_bit_add

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one four_bit_add between NUM_REQ valid/ready requesters;
// the registered result and winner ID leave on a valid/ready response port.
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [SUM_W-1:0]          rsp_sum,
    output logic [ID_W-1:0]           rsp_id
);

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [NUM_REQ-1:0]  grant;
    logic [ID_W-1:0]     gnt_idx;
    logic                gnt_any;
    logic                can_issue;
    logic                accept;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [SUM_W-1:0]    add_sum;
    logic [ID_W-1:0]     ptr_next;

    // Two passes give the circular scan rr_ptr..NUM_REQ-1 then 0..rr_ptr-1.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!gnt_any && req_valid[i] && (i >= 32'(rr_ptr))) begin
                gnt_any  = 1'b1;
                gnt_idx  = ID_W'(i);
                grant[i] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!gnt_any && req_valid[i]) begin
                gnt_any  = 1'b1;
                gnt_idx  = ID_W'(i);
                grant[i] = 1'b1;
            end
        end
    end

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                op_a = req_a[DATA_W*i +: DATA_W];
                op_b = req_b[DATA_W*i +: DATA_W];
            end
        end
    end

    four_bit_add u_add (
        .a   (op_a),
        .b   (op_b),
        .sum (add_sum)
    );

    // Gating on rst keeps a request from looking accepted while reset is held.
    assign can_issue = ~rst & ((state == ST_IDLE) | rsp_ready);
    assign req_ready = grant & {NUM_REQ{can_issue}};
    assign accept    = gnt_any & can_issue;
    assign ptr_next  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_id    <= '0;
            rr_ptr    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_HOLD;
                        rsp_valid <= 1'b1;
                        rsp_sum   <= add_sum;
                        rsp_id    <= gnt_idx;
                        rr_ptr    <= ptr_next;
                    end
                end
                ST_HOLD: begin
                    if (accept) begin
                        rsp_valid <= 1'b1;
                        rsp_sum   <= add_sum;
                        rsp_id    <= gnt_idx;
                        rr_ptr    <= ptr_next;
                    end else if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : adder_share_arbiter

// File: tb/tb_adder_share_arbiter.sv
// Directed self-checking bench for adder_share_arbiter with NUM_REQ=2.
module tb_adder_share_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [4:0] rsp_sum;
    logic [0:0] rsp_id;

    int checks   = 0;
    int failures = 0;

    adder_share_arbiter #(.NUM_REQ(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [4:0] s, input logic id);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'(v));
        chk({tag, "_sum"},   32'(rsp_sum),   32'(s));
        chk({tag, "_id"},    32'(rsp_id),    32'(id));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 2'b00;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #2;
        chk_rsp("reset", 1'b0, 5'd0, 1'b0);
        chk("reset_ready", 32'(req_ready), 32'(2'b00));
        #10;
        rst = 1'b0;

        // 1: req0 0+1
        req_valid = 2'b01;
        req_a     = 8'h00;
        req_b     = 8'h01;
        #1;
        chk("t1_ready", 32'(req_ready), 32'(2'b01));
        step();
        chk_rsp("t1", 1'b1, 5'b00001, 1'b0);

        // 2: req1 15+15, then req0 0+5
        req_valid = 2'b10;
        req_a     = 8'hF0;
        req_b     = 8'hF0;
        #1;
        chk("t2a_ready", 32'(req_ready), 32'(2'b10));
        step();
        chk_rsp("t2a", 1'b1, 5'b11110, 1'b1);
        req_valid = 2'b01;
        req_a     = 8'h00;
        req_b     = 8'h05;
        step();
        chk_rsp("t2b", 1'b1, 5'b00101, 1'b0);
        req_valid = 2'b00;
        step();
        chk("t2_drain_valid", 32'(rsp_valid), 32'(1'b0));

        // 3: both valid from reset -> 0,1,0,1
        #2;
        rst = 1'b1;
        #2;
        req_valid = 2'b11;
        req_a     = 8'h31;
        req_b     = 8'h42;
        #1;
        rst = 1'b0;
        #1;
        chk("t3_ready0", 32'(req_ready), 32'(2'b01));
        step();
        chk_rsp("t3_g0", 1'b1, 5'd3, 1'b0);
        chk("t3_ready1", 32'(req_ready), 32'(2'b10));
        step();
        chk_rsp("t3_g1", 1'b1, 5'd7, 1'b1);
        step();
        chk_rsp("t3_g2", 1'b1, 5'd3, 1'b0);
        step();
        chk_rsp("t3_g3", 1'b1, 5'd7, 1'b1);

        // 4: backpressure for 3 cycles
        rsp_ready = 1'b0;
        #1;
        chk("t4_ready_bp", 32'(req_ready), 32'(2'b00));
        for (int c = 0; c < 3; c++) begin
            step();
            chk_rsp("t4_hold", 1'b1, 5'd7, 1'b1);
            chk("t4_hold_ready", 32'(req_ready), 32'(2'b00));
        end
        rsp_ready = 1'b1;
        #1;
        chk("t4_release_ready", 32'(req_ready), 32'(2'b01));
        step();
        chk_rsp("t4_next", 1'b1, 5'd3, 1'b0);

        // 5: only req1 for 4 requests, then req0 returns
        req_valid = 2'b10;
        req_a     = 8'h21;
        req_b     = 8'h92;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("t5_ready1", 32'(req_ready), 32'(2'b10));
            step();
            chk_rsp("t5_g1", 1'b1, 5'h0B, 1'b1);
        end
        req_valid = 2'b11;
        #1;
        chk("t5_ready0", 32'(req_ready), 32'(2'b01));
        step();
        chk_rsp("t5_g0", 1'b1, 5'd3, 1'b0);

        // 6: async reset mid-stream; rr_ptr is 1 here, so req0 winning proves the reset
        #3;
        rst = 1'b1;
        #1;
        chk_rsp("t6_rst", 1'b0, 5'd0, 1'b0);
        chk("t6_rst_ready", 32'(req_ready), 32'(2'b00));
        #2;
        rst = 1'b0;
        #1;
        chk("t6_post_ready", 32'(req_ready), 32'(2'b01));
        chk("t6_post_valid", 32'(rsp_valid), 32'(1'b0));
        step();
        chk_rsp("t6_first", 1'b1, 5'd3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_adder_share_arbiter
